// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: derives per-stage write enables, flush and bubble
// from hazard, branch and memory handshakes, with a data-memory timeout watchdog.
module pipeline_ctrl #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hazard_stall_i,
   input  logic        branch_taken_i,
   input  logic        imem_ready_i,
   input  logic        dmem_req_i,
   input  logic        dmem_ready_i,
   input  logic        perf_clr_i,
   output logic        pc_write_o,
   output logic        ifid_write_o,
   output logic        ifid_flush_o,
   output logic        idex_bubble_o,
   output logic        exmem_write_o,
   output logic        memwb_write_o,
   output logic        err_o,
   output logic [31:0] stall_cycles_o,
   output logic [15:0] flush_cnt_o
);

   localparam int unsigned WAIT_W  = 8;
   localparam int unsigned STALL_W = 32;
   localparam int unsigned FLUSH_W = 16;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [WAIT_W-1:0]    wait_cnt_q;
   logic [WAIT_W-1:0]    wait_cnt_d;
   logic                 err_q;
   logic [STALL_W-1:0]   stall_cnt_q;
   logic [FLUSH_W-1:0]   flush_cnt_q;
   logic                 mem_wait;
   logic                 redirect;

   // State register and timeout counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next state plus Mealy outputs; priority HALT > memory wait > hazard > branch > fetch wait
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_wait      = 1'b0;
      redirect      = 1'b0;
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      exmem_write_o = 1'b1;
      memwb_write_o = 1'b1;

      case (state_q)
         ST_RUN: begin
            if (dmem_req_i && !dmem_ready_i) begin
               mem_wait   = 1'b1;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (!dmem_ready_i) begin
               mem_wait = 1'b1;
               if (wait_cnt_q == TIMEOUT) begin
                  state_d = ST_HALT;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end else begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase

      if (state_q == ST_HALT || mem_wait) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         exmem_write_o = 1'b0;
         memwb_write_o = 1'b0;
      end else if (hazard_stall_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
         ifid_flush_o = 1'b1;
         redirect     = 1'b1;
      end else if (!imem_ready_i) begin
         pc_write_o   = 1'b0;
         ifid_flush_o = 1'b1;
      end

      // Everything quiet while reset is held
      if (rst_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         ifid_flush_o  = 1'b0;
         idex_bubble_o = 1'b0;
         exmem_write_o = 1'b0;
         memwb_write_o = 1'b0;
         redirect      = 1'b0;
      end
   end

   // Sticky timeout error, cleared only by reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (state_d == ST_HALT) begin
         err_q <= 1'b1;
      end
   end

   // Saturating performance counters; clear beats increment
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (perf_clr_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_write_o && (stall_cnt_q != {STALL_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
         end
         if (redirect && (flush_cnt_q != {FLUSH_W{1'b1}})) begin
            flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
         end
      end
   end

   assign err_o          = err_q;
   assign stall_cycles_o = stall_cnt_q;
   assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (TIMEOUT=4): enable patterns per condition,
// counter saturation/clear, timeout to HALT and reset recovery.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        hz, br, im, rq, rd, clr;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write;
   logic        err;
   logic [31:0] stall_cycles;
   logic [15:0] flush_cnt;
   logic [5:0]  ctl;

   int checks = 0;
   int errors = 0;

   // {pc, ifid, flush, bubble, exmem, memwb}
   localparam logic [5:0] C_NORM  = 6'b110011;
   localparam logic [5:0] C_STALL = 6'b000000;
   localparam logic [5:0] C_HAZ   = 6'b000111;
   localparam logic [5:0] C_BR    = 6'b111011;
   localparam logic [5:0] C_FETCH = 6'b011011;

   pipeline_ctrl #(.TIMEOUT(8'd4)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .hazard_stall_i (hz),
      .branch_taken_i (br),
      .imem_ready_i   (im),
      .dmem_req_i     (rq),
      .dmem_ready_i   (rd),
      .perf_clr_i     (clr),
      .pc_write_o     (pc_write),
      .ifid_write_o   (ifid_write),
      .ifid_flush_o   (ifid_flush),
      .idex_bubble_o  (idex_bubble),
      .exmem_write_o  (exmem_write),
      .memwb_write_o  (memwb_write),
      .err_o          (err),
      .stall_cycles_o (stall_cycles),
      .flush_cnt_o    (flush_cnt)
   );

   assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic h, input logic b, input logic i,
                        input logic q, input logic d, input logic c);
      hz = h; br = b; im = i; rq = q; rd = d; clr = c;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      check("rst_ctl", 32'(ctl), 32'(C_STALL));
      check("rst_stall", stall_cycles, 32'd0);
      check("rst_flush", 32'(flush_cnt), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      @(negedge clk);
      rst = 1'b0;
      #1 check("norm_ctl", 32'(ctl), 32'(C_NORM));
      next_cycle();
      check("norm_stall", stall_cycles, 32'd0);

      // single-cycle hazard
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 check("haz_ctl", 32'(ctl), 32'(C_HAZ));
      next_cycle();
      check("haz_stall", stall_cycles, 32'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 check("haz_after_ctl", 32'(ctl), 32'(C_NORM));
      next_cycle();

      // hazard beats branch
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 check("haz_br_ctl", 32'(ctl), 32'(C_HAZ));
      next_cycle();
      check("haz_br_flush", 32'(flush_cnt), 32'd0);
      check("haz_br_stall", stall_cycles, 32'd2);

      // branch beats fetch wait
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("br_im0_ctl", 32'(ctl), 32'(C_BR));
      next_cycle();
      check("br_im0_flush", 32'(flush_cnt), 32'd1);
      check("br_im0_stall", stall_cycles, 32'd2);

      // fetch wait
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("fetch_ctl", 32'(ctl), 32'(C_FETCH));
      next_cycle();
      check("fetch_stall", stall_cycles, 32'd3);

      // clear wins over a simultaneous stall increment
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      #1 check("clr_ctl", 32'(ctl), 32'(C_HAZ));
      next_cycle();
      check("clr_stall", stall_cycles, 32'd0);
      check("clr_flush", 32'(flush_cnt), 32'd0);

      // three-cycle memory wait, then completion
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1 check("mw_ctl", 32'(ctl), 32'(C_STALL));
         next_cycle();
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      #1 check("mw_done_ctl", 32'(ctl), 32'(C_NORM));
      next_cycle();
      check("mw_stall", stall_cycles, 32'd3);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 check("run_rd_ignored", 32'(ctl), 32'(C_NORM));
      next_cycle();

      // completion cycle falls through to the hazard rule
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      #1 check("mw2_ctl", 32'(ctl), 32'(C_STALL));
      next_cycle();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      #1 check("mw_release_haz", 32'(ctl), 32'(C_HAZ));
      next_cycle();
      check("mw2_stall", stall_cycles, 32'd5);

      // dmem_req_i dropping during wait does not end it
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      next_cycle();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 check("mw_req_ignored", 32'(ctl), 32'(C_STALL));
      next_cycle();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      #1 check("mw3_done_ctl", 32'(ctl), 32'(C_NORM));
      next_cycle();
      check("mw3_stall", stall_cycles, 32'd7);

      // stall counter saturation, then clear under stall
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      next_cycle();
      release dut.stall_cnt_q;
      next_cycle();
      check("stall_sat", stall_cycles, 32'hFFFF_FFFF);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      next_cycle();
      check("stall_sat_clr", stall_cycles, 32'd0);

      // flush counter saturation
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      force dut.flush_cnt_q = 16'hFFFF;
      next_cycle();
      release dut.flush_cnt_q;
      next_cycle();
      check("flush_sat", 32'(flush_cnt), 32'h0000_FFFF);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      next_cycle();
      check("flush_sat_clr", 32'(flush_cnt), 32'd0);

      // timeout: five wait cycles then HALT
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1 check("to_ctl", 32'(ctl), 32'(C_STALL));
         check("to_err_low", 32'(err), 32'd0);
         next_cycle();
      end
      check("to_err_set", 32'(err), 32'd1);
      check("to_stall", stall_cycles, 32'd5);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1 check("halt_ctl", 32'(ctl), 32'(C_STALL));
         next_cycle();
         check("halt_err", 32'(err), 32'd1);
      end
      check("halt_stall", stall_cycles, 32'd8);

      // asynchronous reset out of HALT
      rst = 1'b1;
      #1;
      check("rst_halt_ctl", 32'(ctl), 32'(C_STALL));
      check("rst_halt_err", 32'(err), 32'd0);
      check("rst_halt_stall", stall_cycles, 32'd0);
      next_cycle();
      rst = 1'b0;
      #1 check("post_rst_ctl", 32'(ctl), 32'(C_NORM));
      next_cycle();
      check("post_rst_err", 32'(err), 32'd0);

      // reset mid-wait
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      next_cycle();
      next_cycle();
      rst = 1'b1;
      #1;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
      rst = 1'b0;
      #1 check("rst_mw_ctl", 32'(ctl), 32'(C_NORM));
      next_cycle();
      check("rst_mw_stall", stall_cycles, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 8'd255, max consecutive MEM_WAIT cycles before HALT.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset; asynchronous, active-high.
REQ-004 hazard_stall_i  in  1  stall request from the hazard detector (load-use / branch operand hazard).
REQ-005 branch_taken_i  in  1  branch resolved taken in ID this cycle.
REQ-006 imem_ready_i  in  1  instruction fetch data valid this cycle.
REQ-007 dmem_req_i  in  1  MEM-stage load/store active this cycle.
REQ-008 dmem_ready_i  in  1  data memory completes access this cycle.
REQ-009 perf_clr_i  in  1  synchronous clear of performance counters.
REQ-010 pc_write_o  out  1  PC update enable.
REQ-011 ifid_write_o  out  1  IF/ID register write enable.
REQ-012 ifid_flush_o  out  1  load NOP into IF/ID at next edge.
REQ-013 idex_bubble_o  out  1  load NOP control into ID/EX at next edge.
REQ-014 exmem_write_o  out  1  EX/MEM register write enable.
REQ-015 memwb_write_o  out  1  MEM/WB register write enable.
REQ-016 err_o  out  1  sticky memory-timeout error.
REQ-017 stall_cycles_o  out  32  saturating count of cycles with pc_write_o=0.
REQ-018 flush_cnt_o  out  16  saturating count of branch redirects.

Function
REQ-019 States: RUN, MEM_WAIT, HALT; 8-bit wait counter wait_cnt.
REQ-020 Outputs are combinational from state and current inputs (Mealy); zero latency.
REQ-021 Condition priority, highest first: HALT > memory wait > hazard_stall_i > branch_taken_i > !imem_ready_i > normal.
REQ-022 Normal: all five write enables 1; ifid_flush_o=0; idex_bubble_o=0.
REQ-023 Memory wait (dmem_req_i=1 and dmem_ready_i=0 in RUN, or dmem_ready_i=0 in MEM_WAIT): all write enables 0, flush/bubble 0.
REQ-024 Hazard stall: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, exmem_write_o=1, memwb_write_o=1, ifid_flush_o=0.
REQ-025 Branch taken: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, others per normal; flush_cnt_o increments.
REQ-026 Fetch wait (!imem_ready_i, no higher condition): pc_write_o=0, ifid_write_o=1, ifid_flush_o=1, downstream per normal.
REQ-027 RUN -> MEM_WAIT when dmem_req_i=1 and dmem_ready_i=0; wait_cnt <= 1.
REQ-028 In MEM_WAIT with dmem_ready_i=1: outputs evaluated by REQ-021 rules below memory wait this cycle; next state RUN; wait_cnt <= 0.
REQ-029 In MEM_WAIT with dmem_ready_i=0: wait_cnt increments; if wait_cnt==TIMEOUT, next state HALT instead.
REQ-030 HALT: all write enables 0, flush/bubble 0, err_o=1; exit only by reset.
REQ-031 dmem_req_i ignored in MEM_WAIT (access already outstanding); dmem_ready_i ignored in RUN when dmem_req_i=0.
REQ-032 stall_cycles_o increments every non-reset cycle with pc_write_o=0 (incl. HALT); holds at 32'hFFFFFFFF.
REQ-033 flush_cnt_o holds at 16'hFFFF.
REQ-034 perf_clr_i=1: both counters <= 0 at next edge; clear wins over simultaneous increment; err_o unaffected.

Reset
REQ-035 rst_i=1: state <= RUN, wait_cnt <= 0, counters <= 0, err_o <= 0 immediately, no clock required.
REQ-036 While rst_i=1, all write enables, ifid_flush_o and idex_bubble_o SHALL be 0.
REQ-037 Reset asserted mid-MEM_WAIT or in HALT returns to RUN with normal outputs in first cycle after deassertion.

Verification
REQ-038 hazard_stall_i=1 for 1 cycle, all else normal -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cycles_o=1.
REQ-039 hazard_stall_i=1 and branch_taken_i=1 same cycle -> hazard outputs only, ifid_flush_o=0, flush_cnt_o unchanged.
REQ-040 dmem_req_i=1, dmem_ready_i=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, normal on 4th; state RUN after; stall_cycles_o=3.
REQ-041 TIMEOUT=4, dmem_ready_i held 0 -> HALT after cycle 5 of wait, err_o=1 permanently; rst_i pulse -> err_o=0, RUN.
REQ-042 stall_cycles_o preloaded by 2^32-1 stall cycles (or forced) -> stays 32'hFFFFFFFF; perf_clr_i=1 with stall -> 0 next cycle.
REQ-043 branch_taken_i=1 with imem_ready_i=0 -> pc_write_o=1, ifid_flush_o=1, flush_cnt_o+1.
